sme_issue_ctl: RTL and testbench

Issue controller for the SME share datapath: it accepts masked-operation requests from the pipeline and steers them to the SME ALU or crypto unit using their valid/ready handshakes. It also arbitrates the single share-register-file write port between compute writeback and bank load/store traffic. It tracks destination addresses, reports completions, drops work on flush, and can optionally flag a hung functional unit. It sits between the core decode/execute stage and `sme_state`.

---
 rtl/sme_pkg.sv | 17 +
 rtl/sme_rr_arb2.sv | 35 +++
 rtl/sme_issue_ctl.sv | 146 ++++++++++++++
 tb/tb_sme_issue_ctl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sme_pkg: shared types and unit encodings for the SME share datapath.  Rev 1.0
// ----------------------------------------------------------------------------
package sme_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ALU  = 2'd1,
    CRY  = 2'd2
  } sme_issue_state_t;

  localparam logic SME_UNIT_ALU = 1'b0;
  localparam logic SME_UNIT_CRY = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sme_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sme_rr_arb2: two-requester round-robin arbiter, registered last-grant pointer.
// Rev 1.0
// ----------------------------------------------------------------------------
module sme_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  // r_last = 1 means requester 1 won most recently, so requester 0 has priority.
  logic r_last;

  always_comb begin
    o_gnt0 = i_en && i_req0 && (!i_req1 || r_last);
    o_gnt1 = i_en && i_req1 && (!i_req0 || !r_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b0;
    end else if (o_gnt0) begin
      r_last <= 1'b0;
    end else if (o_gnt1) begin
      r_last <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sme_issue_ctl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sme_issue_ctl: issues ops to the SME ALU/crypto unit and arbitrates the share
// RF port. Optional macro SME_ISSUE_WATCHDOG_EN adds a hung-unit watchdog. Rev 1.0
// ----------------------------------------------------------------------------
module sme_issue_ctl
  import sme_pkg::*;
#(
  parameter int MAX_LAT = 16,
  parameter int CW      = $clog2(MAX_LAT)
) (
  input  logic       g_clk,
  input  logic       g_reset,
  input  logic       flush,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_unit,
  input  logic [3:0] req_rd_addr,
  input  logic       bank_req_valid,
  input  logic       bank_req_write,
  output logic       bank_req_ready,
  output logic       alu_valid,
  input  logic       alu_ready,
  output logic       cry_valid,
  input  logic       cry_ready,
  output logic       bank_wen,
  output logic       bank_read,
  output logic       rsp_valid,
  output logic       rsp_unit,
  output logic [3:0] rsp_rd_addr,
  output logic       busy,
  output logic       err_timeout
);

  sme_issue_state_t r_state;
  logic             r_unit;
  logic [3:0]       r_rd_addr;
  logic             r_alu_valid;
  logic             r_cry_valid;
  logic             r_rsp_valid;
  logic             r_rsp_unit;
  logic [3:0]       r_rsp_rd_addr;

  logic w_arb_en;
  logic w_gnt_req;
  logic w_gnt_bank;
  logic w_fu_ready;

  // Reset gates the enable so the combinational grants are also 0 during reset.
  assign w_arb_en   = (r_state == IDLE) && !flush && !g_reset;
  assign w_fu_ready = (r_state == CRY) ? cry_ready : alu_ready;

  sme_rr_arb2 u_arb (
    .clk    (g_clk),
    .rst    (g_reset),
    .i_en   (w_arb_en),
    .i_req0 (req_valid),
    .i_req1 (bank_req_valid),
    .o_gnt0 (w_gnt_req),
    .o_gnt1 (w_gnt_bank)
  );

`ifdef SME_ISSUE_WATCHDOG_EN
  logic [CW-1:0] r_wdog;
  logic          r_err;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else if (r_state == IDLE) begin
      r_wdog <= '0;
    end else if (!flush && !w_fu_ready) begin
      if (r_wdog == CW'(MAX_LAT - 1)) begin
        r_err <= 1'b1;
      end
      r_wdog <= r_wdog + CW'(1);
    end
  end

  logic w_timeout;
  assign w_timeout   = !flush && !w_fu_ready && (r_wdog == CW'(MAX_LAT - 1));
  assign err_timeout = r_err;
`else
  logic w_timeout;
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0 & (CW == 0);
`endif

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state       <= IDLE;
      r_unit        <= 1'b0;
      r_rd_addr     <= 4'd0;
      r_alu_valid   <= 1'b0;
      r_cry_valid   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_unit    <= 1'b0;
      r_rsp_rd_addr <= 4'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_req) begin
            r_unit      <= req_unit;
            r_rd_addr   <= req_rd_addr;
            r_alu_valid <= (req_unit == SME_UNIT_ALU);
            r_cry_valid <= (req_unit == SME_UNIT_CRY);
            r_state     <= (req_unit == SME_UNIT_CRY) ? CRY : ALU;
          end
        end
        ALU, CRY: begin
          // Flush beats completion; a timed-out op is dropped without a response.
          if (flush || w_fu_ready || w_timeout) begin
            r_state     <= IDLE;
            r_alu_valid <= 1'b0;
            r_cry_valid <= 1'b0;
          end
          if (!flush && w_fu_ready) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_unit    <= r_unit;
            r_rsp_rd_addr <= r_rd_addr;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_alu_valid <= 1'b0;
          r_cry_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = w_gnt_req;
  assign bank_req_ready = w_gnt_bank;
  assign bank_wen       = w_gnt_bank && bank_req_write;
  assign bank_read      = w_gnt_bank && !bank_req_write;
  assign alu_valid      = r_alu_valid;
  assign cry_valid      = r_cry_valid;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_unit       = r_rsp_unit;
  assign rsp_rd_addr    = r_rsp_rd_addr;
  assign busy           = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sme_issue_ctl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sme_issue_ctl: directed scenarios plus randomized traffic against a
// transaction-level model of the issue controller.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_sme_issue_ctl;

`ifdef SME_ISSUE_WATCHDOG_EN
  localparam int MAX_LAT = 4;
  localparam bit WDOG    = 1'b1;
`else
  localparam int MAX_LAT = 16;
  localparam bit WDOG    = 1'b0;
`endif

  logic       g_clk = 1'b0;
  logic       g_reset, flush, req_valid, req_unit;
  logic [3:0] req_rd_addr;
  logic       bank_req_valid, bank_req_write, alu_ready, cry_ready;
  logic       req_ready, bank_req_ready, alu_valid, cry_valid, bank_wen, bank_read;
  logic       rsp_valid, rsp_unit, busy, err_timeout;
  logic [3:0] rsp_rd_addr;

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  sme_issue_ctl #(.MAX_LAT(MAX_LAT)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_unit(req_unit),
    .req_rd_addr(req_rd_addr), .bank_req_valid(bank_req_valid),
    .bank_req_write(bank_req_write), .bank_req_ready(bank_req_ready),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .cry_valid(cry_valid), .cry_ready(cry_ready),
    .bank_wen(bank_wen), .bank_read(bank_read),
    .rsp_valid(rsp_valid), .rsp_unit(rsp_unit), .rsp_rd_addr(rsp_rd_addr),
    .busy(busy), .err_timeout(err_timeout)
  );

  function automatic logic [13:0] all_outs();
    return {req_ready, bank_req_ready, alu_valid, cry_valid, bank_wen, bank_read,
            rsp_valid, rsp_unit, rsp_rd_addr, busy, err_timeout};
  endfunction

  task automatic idle_inputs();
    flush = 0; req_valid = 0; req_unit = 0; req_rd_addr = 0;
    bank_req_valid = 0; bank_req_write = 0; alu_ready = 0; cry_ready = 0;
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    g_reset = 1;
    tick(); tick();
    g_reset = 0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    g_reset = 1;
    req_valid = 1; bank_req_valid = 1;
    #2;
    checks++;
    if (all_outs() !== 14'd0) begin
      errors++; $display("FAIL reset_outs: got %b expected %b", all_outs(), 14'd0);
    end
    tick();
    g_reset = 0;
    idle_inputs();
    tick();
    checks++;
    if (all_outs() !== 14'd0) begin
      errors++; $display("FAIL post_reset_idle: got %b expected %b", all_outs(), 14'd0);
    end
  endtask

  task automatic test_alu_latency();
    int cnt = 0;
    do_reset();
    req_valid = 1; req_unit = 0; req_rd_addr = 4'd5;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL alu_accept: got %b expected 1", req_ready);
    end
    tick();
    req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      alu_ready = (i == 2);
      #1;
      if (alu_valid === 1'b1) cnt++;
      tick();
    end
    alu_ready = 0;
    #1;
    checks++;
    if (cnt != 3 || alu_valid !== 1'b0) begin
      errors++; $display("FAIL alu_valid_width: got %0d cycles (now %b) expected 3 (now 0)", cnt, alu_valid);
    end
    checks++;
    if ({rsp_valid, rsp_unit, rsp_rd_addr, busy} !== {1'b1, 1'b0, 4'd5, 1'b0}) begin
      errors++; $display("FAIL alu_rsp: got v=%b u=%b rd=%0d busy=%b expected v=1 u=0 rd=5 busy=0",
                         rsp_valid, rsp_unit, rsp_rd_addr, busy);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rsp_one_cycle: got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_contention();
    // Pointer resets to compute, so bank wins the first contested cycle.
    string exp_seq = "BC-BC-";
    string got_seq = "";
    bit collide = 0;
    do_reset();
    req_valid = 1; req_unit = 0; req_rd_addr = 4'd3;
    bank_req_valid = 1; bank_req_write = 1; alu_ready = 1; cry_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bank_req_ready && busy) collide = 1;
      got_seq = {got_seq, req_ready ? "C" : (bank_req_ready ? "B" : "-")};
      tick();
    end
    idle_inputs();
    checks++;
    if (got_seq != exp_seq) begin
      errors++; $display("FAIL contention_order: got %s expected %s", got_seq, exp_seq);
    end
    checks++;
    if (collide) begin
      errors++; $display("FAIL bank_during_busy: got 1 expected 0");
    end
  endtask

  task automatic test_flush();
    do_reset();
    req_valid = 1; req_unit = 1; req_rd_addr = 4'($urandom_range(0, 15));
    tick();
    req_valid = 0;
    #1;
    checks++;
    if ({cry_valid, busy} !== 2'b11) begin
      errors++; $display("FAIL cry_issue: got %b expected 11", {cry_valid, busy});
    end
    tick();
    cry_ready = 1; flush = 1;
    tick();
    cry_ready = 0; flush = 0;
    #1;
    checks++;
    if ({cry_valid, busy, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL flush_drop: got %b expected 000", {cry_valid, busy, rsp_valid});
    end
    flush = 1; req_valid = 1; bank_req_valid = 1;
    #1;
    checks++;
    if ({req_ready, bank_req_ready} !== 2'b00) begin
      errors++; $display("FAIL flush_idle_block: got %b expected 00", {req_ready, bank_req_ready});
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL flush_idle_after: got %b expected 00", {busy, rsp_valid});
    end
  endtask

  task automatic test_bank();
    do_reset();
    bank_req_valid = 1; bank_req_write = 1;
    #1;
    checks++;
    if ({bank_req_ready, bank_wen, bank_read} !== 3'b110) begin
      errors++; $display("FAIL bank_write: got %b expected 110", {bank_req_ready, bank_wen, bank_read});
    end
    tick();
    bank_req_write = 0;
    #1;
    checks++;
    if ({bank_req_ready, bank_wen, bank_read, busy} !== 4'b1010) begin
      errors++; $display("FAIL bank_read: got %b expected 1010", {bank_req_ready, bank_wen, bank_read, busy});
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL bank_stays_idle: got %b expected 0", busy);
    end
  endtask

  task automatic test_watchdog();
    int cnt = 0;
    do_reset();
    req_valid = 1; req_unit = 0; req_rd_addr = 4'd9;
    tick();
    req_valid = 0;
    for (int i = 0; i < MAX_LAT + 4; i++) begin
      #1;
      if (alu_valid === 1'b1) cnt++;
      tick();
    end
    checks++;
    if (cnt != MAX_LAT || err_timeout !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL watchdog_trip: got cycles=%0d err=%b busy=%b expected cycles=%0d err=1 busy=0",
                         cnt, err_timeout, busy, MAX_LAT);
    end
    req_valid = 1; req_unit = 1; req_rd_addr = 4'd2;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL watchdog_next_req: got %b expected 1", req_ready);
    end
    tick();
    req_valid = 0; cry_ready = 1;
    tick();
    cry_ready = 0;
    #1;
    checks++;
    if ({rsp_valid, rsp_unit, rsp_rd_addr, err_timeout} !== {1'b1, 1'b1, 4'd2, 1'b1}) begin
      errors++; $display("FAIL watchdog_sticky: got %b expected %b",
                         {rsp_valid, rsp_unit, rsp_rd_addr, err_timeout}, {1'b1, 1'b1, 4'd2, 1'b1});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 1; req_unit = 0; req_rd_addr = 4'd7;
    tick();
    req_valid = 0;
    tick();
    #2;
    g_reset = 1;
    #1;
    checks++;
    if (all_outs() !== 14'd0) begin
      errors++; $display("FAIL async_reset_outs: got %b expected %b", all_outs(), 14'd0);
    end
    tick();
    g_reset = 0;
    tick();
    req_valid = 1; req_unit = 0; req_rd_addr = 4'd11;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_then_accept: got %b expected 1", req_ready);
    end
    tick();
    req_valid = 0; alu_ready = 1;
    tick();
    alu_ready = 0;
    #1;
    checks++;
    if ({rsp_valid, rsp_unit, rsp_rd_addr} !== {1'b1, 1'b0, 4'd11}) begin
      errors++; $display("FAIL reset_then_rsp: got %b expected %b",
                         {rsp_valid, rsp_unit, rsp_rd_addr}, {1'b1, 1'b0, 4'd11});
    end
  endtask

  // Model: at most one outstanding op, a last-winner flag, and a pending response.
  task automatic test_random(input int n);
    bit m_op = 0, m_unit = 0, m_last = 0, m_rsp = 0, m_rsp_unit = 0, m_err = 0;
    logic [3:0] m_addr = 0, m_rsp_addr = 0;
    int m_age = 0;
    bit e_rr, e_br;
    do_reset();
    for (int c = 0; c < n; c++) begin
      req_valid      = 1'($urandom_range(0, 1));
      req_unit       = 1'($urandom_range(0, 1));
      req_rd_addr    = 4'($urandom_range(0, 15));
      bank_req_valid = 1'($urandom_range(0, 1));
      bank_req_write = 1'($urandom_range(0, 1));
      alu_ready      = ($urandom_range(0, 3) == 0);
      cry_ready      = ($urandom_range(0, 3) == 0);
      flush          = ($urandom_range(0, 15) == 0);
      #1;
      e_rr = 0; e_br = 0;
      if (!m_op && !flush) begin
        if (req_valid && bank_req_valid) begin
          e_rr = m_last; e_br = !m_last;
        end else begin
          e_rr = req_valid; e_br = bank_req_valid;
        end
      end
      checks++;
      if ({req_ready, bank_req_ready, bank_wen, bank_read} !==
          {e_rr, e_br, e_br && bank_req_write, e_br && !bank_req_write}) begin
        errors++; $display("FAIL rnd_grant cyc %0d: got %b expected %b", c,
                           {req_ready, bank_req_ready, bank_wen, bank_read},
                           {e_rr, e_br, e_br && bank_req_write, e_br && !bank_req_write});
      end
      checks++;
      if ({busy, alu_valid, cry_valid} !== {m_op, m_op && !m_unit, m_op && m_unit}) begin
        errors++; $display("FAIL rnd_issue cyc %0d: got %b expected %b", c,
                           {busy, alu_valid, cry_valid}, {m_op, m_op && !m_unit, m_op && m_unit});
      end
      checks++;
      if (rsp_valid !== m_rsp || (m_rsp && {rsp_unit, rsp_rd_addr} !== {m_rsp_unit, m_rsp_addr})) begin
        errors++; $display("FAIL rnd_rsp cyc %0d: got %b expected %b", c,
                           {rsp_valid, rsp_unit, rsp_rd_addr}, {m_rsp, m_rsp_unit, m_rsp_addr});
      end
      checks++;
      if (err_timeout !== m_err) begin
        errors++; $display("FAIL rnd_err cyc %0d: got %b expected %b", c, err_timeout, m_err);
      end
      m_rsp = 0;
      if (m_op) begin
        if (flush) begin
          m_op = 0;
        end else if (m_unit ? cry_ready : alu_ready) begin
          m_op = 0; m_rsp = 1; m_rsp_unit = m_unit; m_rsp_addr = m_addr;
        end else begin
          m_age++;
          if (WDOG && m_age == MAX_LAT) begin
            m_op = 0; m_err = 1;
          end
        end
      end else if (e_rr) begin
        m_op = 1; m_unit = req_unit; m_addr = req_rd_addr; m_age = 0; m_last = 0;
      end else if (e_br) begin
        m_last = 1;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    g_reset = 1;
    test_reset();
    test_alu_latency();
    test_contention();
    test_flush();
    test_bank();
    if (WDOG) test_watchdog();
    test_async_reset();
    test_random(2000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
